// File: rtl/systolic_feeder.sv
// systolic_feeder: streams unskewed A-column / B-row beats into a DIM x DIM
// output-stationary systolic array, generating the diagonal skew internally
// and tracking feed/drain progress so that done marks the moment the last
// partial product reaches the far-corner PE.
module systolic_feeder #(
   parameter int DATA_WIDTH  = 16,
   parameter int DIM         = 4,
   parameter int K_MAX       = 16,
   parameter int DRAIN_EXTRA = 0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [$clog2(K_MAX+1)-1:0]     k_len,
   input  logic                           pause,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DIM*DATA_WIDTH-1:0]      a_col,
   input  logic [DIM*DATA_WIDTH-1:0]      b_row,
   output logic [DIM*DATA_WIDTH-1:0]      left_data,
   output logic [DIM-1:0]                 left_valid,
   output logic [DIM*DATA_WIDTH-1:0]      top_data,
   output logic [DIM-1:0]                 top_valid,
   output logic                           busy,
   output logic                           done
);

   localparam int KW = $clog2(K_MAX+1);
   // The drain covers the skew tail plus the hop count to PE[DIM-1][DIM-1],
   // so done lands K + 2*DIM + DRAIN_EXTRA cycles after the first accept.
   localparam int DRAIN_CYCLES = 2*DIM + 1 + DRAIN_EXTRA;
   localparam int CW = $clog2(DRAIN_CYCLES+1);
   localparam logic [KW-1:0] K_MAX_W   = KW'(K_MAX);
   localparam logic [CW-1:0] DRAIN_END = CW'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

   state_t          state, state_next;
   logic [KW-1:0]   k_lat, k_lat_next;
   logic [KW-1:0]   beat_cnt, beat_cnt_next;
   logic [CW-1:0]   drain_cnt, drain_cnt_next;
   logic [KW-1:0]   k_clamped;
   logic            advance;
   logic            accept;

   // Everything (chain, counters, FSM) moves only on unpaused cycles.
   assign advance   = !pause;
   assign accept    = in_valid && in_ready;
   assign k_clamped = (k_len > K_MAX_W) ? K_MAX_W : k_len;

   // Control state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         k_lat     <= '0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         state     <= state_next;
         k_lat     <= k_lat_next;
         beat_cnt  <= beat_cnt_next;
         drain_cnt <= drain_cnt_next;
      end
   end

   // Next-state, counter updates and handshake / status outputs.
   always_comb begin
      state_next     = state;
      k_lat_next     = k_lat;
      beat_cnt_next  = beat_cnt;
      drain_cnt_next = drain_cnt;
      in_ready       = 1'b0;
      done           = 1'b0;
      busy           = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (advance && start) begin
               beat_cnt_next = '0;
               k_lat_next    = k_clamped;
               state_next    = (k_clamped == '0) ? S_DONE : S_FEED;
            end
         end
         S_FEED: begin
            in_ready = advance;
            if (accept) begin
               if (beat_cnt == k_lat - KW'(1)) begin
                  state_next     = S_DRAIN;
                  drain_cnt_next = '0;
               end else begin
                  beat_cnt_next = beat_cnt + KW'(1);
               end
            end
         end
         S_DRAIN: begin
            if (advance) begin
               if (drain_cnt == DRAIN_END) state_next = S_DONE;
               else drain_cnt_next = drain_cnt + CW'(1);
            end
         end
         S_DONE: begin
            // Held through a pause so the pulse is seen exactly once.
            done = advance;
            if (advance) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Skew lanes: lane i is a chain of i+1 registers shared by A and B valid.
   for (genvar i = 0; i < DIM; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] a_sr [0:i];
      logic [DATA_WIDTH-1:0] b_sr [0:i];
      logic [i:0]            v_sr;

      // Shift one slot per unpaused cycle; bubbles and drain inject zeros.
      always_ff @(posedge clk) begin
         if (reset) begin
            v_sr <= '0;
            for (int s = 0; s <= i; s++) begin
               a_sr[s] <= '0;
               b_sr[s] <= '0;
            end
         end else if (advance) begin
            v_sr[0] <= accept;
            a_sr[0] <= accept ? a_col[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            b_sr[0] <= accept ? b_row[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            for (int s = 1; s <= i; s++) begin
               v_sr[s] <= v_sr[s-1];
               a_sr[s] <= a_sr[s-1];
               b_sr[s] <= b_sr[s-1];
            end
         end
      end

      // Valids are masked during a stall; data is zero whenever not valid.
      assign left_valid[i] = v_sr[i] && !pause;
      assign top_valid[i]  = v_sr[i] && !pause;
      assign left_data[i*DATA_WIDTH +: DATA_WIDTH] = left_valid[i] ? a_sr[i] : '0;
      assign top_data[i*DATA_WIDTH +: DATA_WIDTH]  = top_valid[i]  ? b_sr[i] : '0;
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: randomized scoreboard bench for systolic_feeder.
// Expected lane beats and done pulses are queued when stimulus is issued,
// tagged with the count of unpaused clock edges at which they must appear.
module tb_systolic_feeder;
   localparam int DW    = 16;
   localparam int DIM   = 4;
   localparam int K_MAX = 16;
   localparam int DE    = 0;
   localparam int KW    = $clog2(K_MAX+1);
   // done appears K + 2*DIM + DE cycles after the first accept, i.e. this
   // many unpaused edges after the last accept.
   localparam int DONE_OFS = 2*DIM + DE + 1;

   logic              clk = 0;
   logic              reset = 1;
   logic              start = 0;
   logic [KW-1:0]     k_len = '0;
   logic              pause = 0;
   logic              in_valid = 0;
   logic              in_ready;
   logic [DIM*DW-1:0] a_col = '0;
   logic [DIM*DW-1:0] b_row = '0;
   logic [DIM*DW-1:0] left_data;
   logic [DIM-1:0]    left_valid;
   logic [DIM*DW-1:0] top_data;
   logic [DIM-1:0]    top_valid;
   logic              busy;
   logic              done;

   systolic_feeder #(.DATA_WIDTH(DW), .DIM(DIM), .K_MAX(K_MAX), .DRAIN_EXTRA(DE)) dut (
      .clk(clk), .reset(reset), .start(start), .k_len(k_len), .pause(pause),
      .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
      .left_data(left_data), .left_valid(left_valid), .top_data(top_data),
      .top_valid(top_valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      int            adv;
   } exp_t;

   exp_t lq [DIM][$];
   exp_t tq [DIM][$];
   int   done_q[$];

   // Reference model state: unpaused-edge count, phase 0 idle / 1 feed / 2 wait done.
   int adv = 0;
   int phase = 0;
   int rem = 0;
   int done_adv = -1;
   int accepts = 0;
   int hs_cnt = 0;
   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name, input longint act, input longint exp);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Behavioural model, evaluated on each rising edge from the driven inputs.
   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            adv = 0; phase = 0; rem = 0; done_adv = -1;
            for (int i = 0; i < DIM; i++) begin
               lq[i].delete();
               tq[i].delete();
            end
            done_q.delete();
         end else if (!pause) begin
            adv++;
            if (phase == 0) begin
               if (start) begin
                  int kk;
                  kk = (int'(k_len) > K_MAX) ? K_MAX : int'(k_len);
                  if (kk == 0) begin
                     done_adv = adv;
                     done_q.push_back(adv);
                     phase = 2;
                  end else begin
                     rem = kk;
                     phase = 1;
                  end
               end
            end else if (phase == 1) begin
               if (in_valid) begin
                  for (int i = 0; i < DIM; i++) begin
                     exp_t e;
                     e.adv  = adv + i;
                     e.data = a_col[i*DW +: DW];
                     lq[i].push_back(e);
                     e.data = b_row[i*DW +: DW];
                     tq[i].push_back(e);
                  end
                  accepts++;
                  rem--;
                  if (rem == 0) begin
                     done_adv = adv + DONE_OFS;
                     done_q.push_back(done_adv);
                     phase = 2;
                  end
               end
            end else begin
               if (adv - 1 == done_adv) phase = 0;
            end
         end
      end
   end

   // Monitor: compares DUT outputs against the queued expectations.
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (in_valid && in_ready) hs_cnt++;
         chk("in_ready", in_ready, (phase == 1) && !pause);
         chk("busy", busy, phase != 0);
         if (pause) chk("valids under pause", {left_valid, top_valid}, 0);
         for (int i = 0; i < DIM; i++) begin
            if (left_valid[i]) begin
               if (lq[i].size() == 0) fail($sformatf("left_valid[%0d] unexpected", i), 1, 0);
               else begin
                  exp_t e;
                  e = lq[i].pop_front();
                  chk($sformatf("left[%0d] timing", i), adv, e.adv);
                  chk($sformatf("left_data[%0d]", i), left_data[i*DW +: DW], e.data);
               end
            end else begin
               chk($sformatf("left_data[%0d] idle", i), left_data[i*DW +: DW], 0);
               if (lq[i].size() > 0 && (lq[i][0].adv < adv || (lq[i][0].adv == adv && !pause))) begin
                  fail($sformatf("left_valid[%0d] missing", i), 0, 1);
                  void'(lq[i].pop_front());
               end
            end
            if (top_valid[i]) begin
               if (tq[i].size() == 0) fail($sformatf("top_valid[%0d] unexpected", i), 1, 0);
               else begin
                  exp_t e;
                  e = tq[i].pop_front();
                  chk($sformatf("top[%0d] timing", i), adv, e.adv);
                  chk($sformatf("top_data[%0d]", i), top_data[i*DW +: DW], e.data);
               end
            end else begin
               chk($sformatf("top_data[%0d] idle", i), top_data[i*DW +: DW], 0);
               if (tq[i].size() > 0 && (tq[i][0].adv < adv || (tq[i][0].adv == adv && !pause))) begin
                  fail($sformatf("top_valid[%0d] missing", i), 0, 1);
                  void'(tq[i].pop_front());
               end
            end
         end
         if (done) begin
            if (done_q.size() == 0) fail("done unexpected", 1, 0);
            else chk("done timing", adv, done_q.pop_front());
         end else if (done_q.size() > 0 && (done_q[0] < adv || (done_q[0] == adv && !pause))) begin
            fail("done missing", 0, 1);
            void'(done_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got 0 expected 1 (simulation time limit)");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      start = 0; in_valid = 0; pause = 0; a_col = '0; b_row = '0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " left_valid"}, left_valid, 0);
      chk({tag, " top_valid"}, top_valid, 0);
      chk({tag, " left_data"}, left_data, 0);
      chk({tag, " top_data"}, top_data, 0);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " in_ready"}, in_ready, 0);
   endtask

   // Drive one beat slot: directed data (lane+1+10*beat) or random.
   task automatic drive_beat(input bit directed, input bit vld, input bit pz, input bit stray);
      int beat;
      beat = accepts;
      in_valid = vld;
      pause = pz;
      start = stray;
      for (int i = 0; i < DIM; i++) begin
         a_col[i*DW +: DW] = directed ? DW'(i + 1 + 10*beat) : DW'($urandom);
         b_row[i*DW +: DW] = directed ? DW'(100 + i + 10*beat) : DW'($urandom);
      end
   endtask

   // One matmul from start to the return to idle.
   task automatic run(input int k, input bit directed, input int bub_at, input int pz_at,
                      input int pz_len, input int bub_pct, input int pz_pct, input bit stray);
      int c;
      set_idle();
      accepts = 0;
      start = 1;
      k_len = KW'(k);
      cyc();
      start = 0;
      c = 0;
      while (phase != 0 && c < 600) begin
         drive_beat(directed,
                    (c != bub_at) && ($urandom_range(99) >= bub_pct),
                    (c >= pz_at && c < pz_at + pz_len) || ($urandom_range(99) < pz_pct),
                    stray && ($urandom_range(3) == 0));
         cyc();
         c++;
      end
      if (c >= 600) fail("matmul cycle budget", c, 600);
      set_idle();
      cyc();
   endtask

   initial begin
      int hs0;
      set_idle();
      reset = 1;
      repeat (3) cyc();
      check_all_zero("reset");
      reset = 0;
      cyc();

      // Back-to-back, directed data; then a bubble; then a 3-cycle pause after beat 2.
      run(4, 1, -1, -1, 0, 0, 0, 0);
      run(4, 1, 2, -1, 0, 0, 0, 0);
      run(4, 1, -1, 2, 3, 0, 0, 0);

      // Zero-length matmul and an over-long one clamped to K_MAX.
      run(0, 0, -1, -1, 0, 0, 0, 0);
      hs0 = hs_cnt;
      run(31, 0, -1, -1, 0, 0, 0, 0);
      chk("beats accepted for k_len=31", hs_cnt - hs0, K_MAX);

      // Start pulses during FEED/DRAIN must be ignored.
      run(8, 0, -1, -1, 0, 0, 0, 1);

      // Reset in the middle of the drain, then a fresh matmul.
      set_idle();
      start = 1; k_len = KW'(3);
      cyc();
      start = 0;
      for (int c = 0; c < 20 && phase == 1; c++) begin
         drive_beat(0, 1, 0, 0);
         cyc();
      end
      set_idle();
      repeat (3) cyc();
      chk("in drain before reset", busy, 1);
      reset = 1;
      cyc();
      check_all_zero("mid-drain reset");
      reset = 0;
      cyc();
      run(5, 1, -1, -1, 0, 0, 0, 0);

      // Randomized mix of lengths, bubbles, stalls and stray starts.
      for (int r = 0; r < 30; r++)
         run($urandom_range(0, 20), 0, -1, -1, 0, $urandom_range(0, 40),
             $urandom_range(0, 30), 1);

      set_idle();
      repeat (12) cyc();
      for (int i = 0; i < DIM; i++) begin
         chk($sformatf("left queue %0d drained", i), lq[i].size(), 0);
         chk($sformatf("top queue %0d drained", i), tq[i].size(), 0);
      end
      chk("done queue drained", done_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
